// File: rtl/tenbr_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// tenbr_pkg : shared 10GBASE-R RX constants and lock FSM states (rev 1.0)
// ------------------------------------------------------------------
package tenbr_pkg;

    localparam int PMA_W = 32;
    localparam int BLK_W = 66;
    localparam int BUF_W = BLK_W + PMA_W - 1;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        LOCK_INIT = 2'd0,
        TEST_SH   = 2'd1,
        SLIP      = 2'd2
    } lock_state_t;

    function automatic logic sh_valid(input logic [1:0] hdr);
        return (hdr == SH_DATA) || (hdr == SH_CTRL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcs_rx_gearbox_32_66.sv
`default_nettype none
// ------------------------------------------------------------------
// pcs_rx_gearbox_32_66 : 32-bit PMA words to 66-bit blocks with bit slip (rev 1.0)
// ------------------------------------------------------------------
module pcs_rx_gearbox_32_66
    import tenbr_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  din,
    input  logic         din_rdy,
    input  logic         slip,
    output logic [1:0]   hdr_nxt,
    output logic         vld_nxt,
    output logic [65:0]  blk,
    output logic         vld
);

    localparam int         CAT_W   = BUF_W + 1;
    localparam logic [6:0] c_pma_w = 7'(PMA_W);
    localparam logic [6:0] c_blk_w = 7'(BLK_W);

    logic [BUF_W-1:0] r_buf;
    logic [6:0]       r_bcnt;
    logic [CAT_W-1:0] w_cat;
    logic [6:0]       w_tot;

    // Bits above r_bcnt in r_buf are always zero, so OR-ing in the new word is safe.
    always_comb begin
        w_cat = {1'b0, r_buf} | (CAT_W'(din) << r_bcnt);
        w_tot = r_bcnt + c_pma_w;
        if (slip) begin
            w_cat = w_cat >> 1;
            w_tot = w_tot - 7'd1;
        end
    end

    assign vld_nxt = din_rdy && (w_tot >= c_blk_w);
    assign hdr_nxt = w_cat[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n || !din_rdy) begin
            r_buf  <= '0;
            r_bcnt <= '0;
            blk    <= '0;
            vld    <= 1'b0;
        end else begin
            vld <= vld_nxt;
            if (vld_nxt) begin
                blk    <= w_cat[BLK_W-1:0];
                r_buf  <= BUF_W'(w_cat >> BLK_W);
                r_bcnt <= w_tot - c_blk_w;
            end else begin
                r_buf  <= w_cat[BUF_W-1:0];
                r_bcnt <= w_tot;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcs_rx_blk_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// pcs_rx_blk_sync : 10GBASE-R RX gearbox plus block-lock state machine (rev 1.0)
// ------------------------------------------------------------------
module pcs_rx_blk_sync
    import tenbr_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int INVLD_MAX = 16
)
(
    input  logic         clk_glbl,
    input  logic         rst_glbl_n,
    input  logic [31:0]  pma_rx,
    input  logic         pma_rx_rdy,
    output logic [1:0]   rx_hdr,
    output logic [63:0]  rx_data,
    output logic         rx_blk_vld,
    output logic         block_lock,
    output logic [15:0]  slip_cnt
);

    localparam logic [6:0] c_lock_cnt  = 7'(LOCK_CNT);
    localparam logic [4:0] c_invld_max = 5'(INVLD_MAX);

    lock_state_t r_state;
    logic [6:0]  r_sh_cnt;
    logic [4:0]  r_invld_cnt;
    logic        r_slip;
    logic [65:0] w_blk;
    logic [1:0]  w_hdr_nxt;
    logic        w_vld_nxt;
    logic        w_bad;
    logic        w_slip_go;
    logic [6:0]  w_sh_inc;
    logic [4:0]  w_invld_inc;

    pcs_rx_gearbox_32_66 u_gearbox (
        .clk     (clk_glbl),
        .rst_n   (rst_glbl_n),
        .din     (pma_rx),
        .din_rdy (pma_rx_rdy),
        .slip    (r_slip),
        .hdr_nxt (w_hdr_nxt),
        .vld_nxt (w_vld_nxt),
        .blk     (w_blk),
        .vld     (rx_blk_vld)
    );

    assign rx_hdr  = w_blk[1:0];
    assign rx_data = w_blk[65:2];

    // The FSM judges the block being registered this cycle, so lock changes line up with its strobe.
    always_comb begin
        w_bad       = !sh_valid(w_hdr_nxt);
        w_sh_inc    = r_sh_cnt + 7'd1;
        w_invld_inc = r_invld_cnt + 5'(w_bad);
        w_slip_go   = pma_rx_rdy && (r_state == TEST_SH) && w_vld_nxt && w_bad &&
                      (!block_lock || (w_invld_inc == c_invld_max));
    end

    always_ff @(posedge clk_glbl) begin
        if (!rst_glbl_n) begin
            slip_cnt <= '0;
        end else if (w_slip_go && (slip_cnt != 16'hFFFF)) begin
            slip_cnt <= slip_cnt + 16'd1;
        end

        if (!rst_glbl_n || !pma_rx_rdy) begin
            r_state     <= LOCK_INIT;
            r_sh_cnt    <= '0;
            r_invld_cnt <= '0;
            r_slip      <= 1'b0;
            block_lock  <= 1'b0;
        end else begin
            r_slip <= 1'b0;
            case (r_state)
                LOCK_INIT: begin
                    block_lock  <= 1'b0;
                    r_sh_cnt    <= '0;
                    r_invld_cnt <= '0;
                    r_state     <= TEST_SH;
                end
                TEST_SH: begin
                    if (w_slip_go) begin
                        block_lock  <= 1'b0;
                        r_slip      <= 1'b1;
                        r_sh_cnt    <= '0;
                        r_invld_cnt <= '0;
                        r_state     <= SLIP;
                    end else if (w_vld_nxt) begin
                        if (w_sh_inc == c_lock_cnt) begin
                            if (w_invld_inc == 5'd0) begin
                                block_lock <= 1'b1;
                            end
                            r_sh_cnt    <= '0;
                            r_invld_cnt <= '0;
                        end else begin
                            r_sh_cnt    <= w_sh_inc;
                            r_invld_cnt <= w_invld_inc;
                        end
                    end
                end
                SLIP: begin
                    r_sh_cnt    <= '0;
                    r_invld_cnt <= '0;
                    r_state     <= TEST_SH;
                end
                default: begin
                    r_state <= LOCK_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcs_rx_blk_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pcs_rx_blk_sync : directed bench for the 10GBASE-R RX block sync (rev 1.0)
// ------------------------------------------------------------------
module tb_pcs_rx_blk_sync;
    import tenbr_pkg::*;

    logic        clk_glbl   = 1'b0;
    logic        rst_glbl_n = 1'b0;
    logic [31:0] pma_rx     = '0;
    logic        pma_rx_rdy = 1'b0;
    logic [1:0]  rx_hdr;
    logic [63:0] rx_data;
    logic        rx_blk_vld;
    logic        block_lock;
    logic [15:0] slip_cnt;

    pcs_rx_blk_sync #(.LOCK_CNT(64), .INVLD_MAX(16)) dut (
        .clk_glbl   (clk_glbl),
        .rst_glbl_n (rst_glbl_n),
        .pma_rx     (pma_rx),
        .pma_rx_rdy (pma_rx_rdy),
        .rx_hdr     (rx_hdr),
        .rx_data    (rx_data),
        .rx_blk_vld (rx_blk_vld),
        .block_lock (block_lock),
        .slip_cnt   (slip_cnt)
    );

    always #5 clk_glbl = ~clk_glbl;

    int          n_pass = 0;
    int          n_tot  = 0;
    int          rxn    = 0;
    int          cur    = 0;
    int          stream_base = 0;
    int          tx_next = 0;
    int          bad_lo = -1;
    int          bad_hi = -1;
    logic [1:0]  bad_val = 2'b00;
    logic [65:0] rxblk  = '0;
    logic [65:0] txb [0:8191];
    bit          txq [$];

    typedef struct {
        logic        rdy;
        logic [31:0] word;
        logic        vld;
        logic        chk_blk;
        logic [1:0]  hdr;
        logic [63:0] data;
        logic        lock;
        logic [15:0] slips;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [65:0] mk_blk(input int i);
        logic [63:0] x;
        x = (64'(i) + 64'd1) * 64'h9E3779B97F4A7C15;
        x = x ^ (x >> 31);
        x = x * 64'hBF58476D1CE4E5B9;
        x = x ^ (x >> 27);
        return {x, (x[40] ? SH_DATA : SH_CTRL)};
    endfunction

    task automatic drive(input logic rstn, input logic rdy, input logic [31:0] w);
        @(negedge clk_glbl);
        rst_glbl_n = rstn;
        pma_rx_rdy = rdy;
        pma_rx     = w;
        @(posedge clk_glbl);
        #1;
        if (rx_blk_vld) begin
            rxn++;
            cur++;
            rxblk = {rx_data, rx_hdr};
        end
    endtask

    task automatic fill();
        logic [65:0] b;
        while (txq.size() < 32) begin
            if (tx_next > 8191) begin
                $display("FAIL tx_overflow: index %0d limit 8191", tx_next);
                $fatal(1, "tx block table exhausted");
            end
            b = mk_blk(tx_next);
            if (tx_next >= bad_lo && tx_next <= bad_hi) b[1:0] = bad_val;
            txb[tx_next] = b;
            for (int k = 0; k < 66; k++) txq.push_back(b[k]);
            tx_next++;
        end
    endtask

    task automatic step_stream();
        logic [31:0] w;
        fill();
        for (int k = 0; k < 32; k++) w[k] = txq.pop_front();
        drive(1'b1, 1'b1, w);
    endtask

    task automatic restart(input int off);
        txq.delete();
        for (int k = 0; k < off; k++) txq.push_back(bit'($urandom_range(1, 0)));
        stream_base = tx_next;
        rxn = 0;
    endtask

    // Aligned stream: every block must match and lock must rise exactly on the 64th.
    task automatic run_aligned(input string tag);
        int mism;
        bit done;
        mism = 0;
        done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            step_stream();
            if (rx_blk_vld) begin
                if (rxblk !== txb[stream_base + rxn - 1]) mism++;
                if (rxn == 63) chk({tag, "_lock_at63"}, block_lock, 1'b0);
                if (rxn == 64) begin
                    chk({tag, "_lock_at64"}, block_lock, 1'b1);
                    done = 1;
                end
            end
        end
        chk({tag, "_reached64"}, done, 1'b1);
        chk({tag, "_payload_mism"}, mism, 0);
    endtask

    initial begin
        int L, s0, s1, mism, strobes;
        bit got, dropped, seen;

        tbl[0] = '{1'b1, 32'hDEADBEE1, 1'b0, 1'b1, 2'b00, 64'h0, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 2'b00, 64'h0, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 32'hFFFFFFFE, 1'b1, 1'b1, 2'b01,
                   {2'b10, 32'h12345678, 30'h37AB6FB8}, 1'b0, 16'd0};
        tbl[3] = '{1'b1, 32'h00000000, 1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 16'd0};
        tbl[4] = '{1'b1, 32'h0000000A, 1'b1, 1'b1, 2'b11,
                   {4'hA, 32'h00000000, 28'hFFFFFFF}, 1'b0, 16'd1};
        tbl[5] = '{1'b0, 32'h55555555, 1'b0, 1'b1, 2'b00, 64'h0, 1'b0, 16'd1};
        tbl[6] = '{1'b1, 32'h00000001, 1'b0, 1'b1, 2'b00, 64'h0, 1'b0, 16'd1};

        drive(1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b1, 32'h0);
        chk("reset_vld", rx_blk_vld, 1'b0);
        chk("reset_lock", block_lock, 1'b0);
        chk("reset_hdr_data", {rx_hdr, rx_data}, 66'h0);
        chk("reset_slip", slip_cnt, 16'd0);

        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tbl[i].rdy, tbl[i].word);
            chk($sformatf("tbl%0d_vld", i), rx_blk_vld, tbl[i].vld);
            chk($sformatf("tbl%0d_lock", i), block_lock, tbl[i].lock);
            chk($sformatf("tbl%0d_slips", i), slip_cnt, tbl[i].slips);
            if (tbl[i].chk_blk) begin
                chk($sformatf("tbl%0d_hdr", i), rx_hdr, tbl[i].hdr);
                chk($sformatf("tbl%0d_data", i), rx_data, tbl[i].data);
            end
        end

        // Aligned stream from reset.
        drive(1'b0, 1'b1, 32'h0);
        restart(0);
        run_aligned("aln");
        chk("aln_slips", slip_cnt, 16'd0);
        strobes = 0;
        for (int c = 0; c < 33; c++) begin
            step_stream();
            if (rx_blk_vld) strobes++;
        end
        chk("aln_strobes_per_33", strobes, 16);

        // Stream offset by 37 bits.
        drive(1'b0, 1'b1, 32'h0);
        restart(37);
        got = 0;
        for (int c = 0; c < 2000 && !got; c++) begin
            step_stream();
            if (block_lock) got = 1;
        end
        chk("off37_lock", got, 1'b1);
        chk("off37_slip_mod66", slip_cnt % 16'd66, 37);
        L = -1;
        for (int k = stream_base; k < tx_next; k++) if (txb[k] === rxblk) L = k;
        chk("off37_block_found", (L >= 0), 1'b1);
        if (L < 0) L = tx_next;
        cur = L;

        // 15 invalid headers at the start of one window: lock holds.
        s0 = int'(slip_cnt);
        bad_lo = L + 65; bad_hi = L + 79; bad_val = 2'b00;
        dropped = 0;
        mism = 0;
        for (int c = 0; c < 600 && cur < L + 128; c++) begin
            step_stream();
            if (!block_lock) dropped = 1;
            if (rx_blk_vld && cur < tx_next && rxblk !== txb[cur]) mism++;
        end
        chk("bad15_reached", (cur >= L + 128), 1'b1);
        chk("bad15_lock_held", dropped, 1'b0);
        chk("bad15_slips", slip_cnt, s0);
        chk("bad15_payload_mism", mism, 0);

        // 16 invalid headers in one window: lock drops on the 16th, one slip.
        bad_lo = L + 193; bad_hi = L + 208; bad_val = 2'b11;
        seen = 0;
        for (int c = 0; c < 600 && cur < L + 208; c++) begin
            step_stream();
            if (rx_blk_vld && cur == L + 207) chk("bad16_lock_at15", block_lock, 1'b1);
            if (rx_blk_vld && cur == L + 208) begin
                chk("bad16_lock_at16", block_lock, 1'b0);
                chk("bad16_one_slip", slip_cnt, s0 + 1);
                seen = 1;
            end
        end
        chk("bad16_reached", seen, 1'b1);
        got = 0;
        for (int c = 0; c < 4000 && !got; c++) begin
            step_stream();
            if (block_lock) got = 1;
        end
        chk("bad16_relock", got, 1'b1);
        chk("bad16_total_slips", int'(slip_cnt) - s0, 66);

        // PMA not ready for 5 cycles while locked.
        chk("pre_drop_lock", block_lock, 1'b1);
        s1 = int'(slip_cnt);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, $urandom);
            chk($sformatf("drop%0d_lock", c), block_lock, 1'b0);
            chk($sformatf("drop%0d_vld", c), rx_blk_vld, 1'b0);
        end
        restart(0);
        run_aligned("rdy");
        chk("rdy_slips_kept", slip_cnt, s1);

        // One-cycle reset while locked.
        chk("pre_rst_lock", block_lock, 1'b1);
        drive(1'b0, 1'b1, 32'hFFFFFFFF);
        chk("rst_vld", rx_blk_vld, 1'b0);
        chk("rst_lock", block_lock, 1'b0);
        chk("rst_hdr_data", {rx_hdr, rx_data}, 66'h0);
        chk("rst_slip", slip_cnt, 16'd0);
        restart(0);
        run_aligned("rst");
        chk("rst_slips_after", slip_cnt, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
